// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 32;

    // Registered status flags, all derived from the next occupancy.
    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } fifo_flags_t;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Simple dual-port storage: one write port, one registered read port.
// Only the read-data register is reset; the array itself is not.
module fifo_ram_2p #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read data holds its value unless a read is accepted.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered read data, occupancy
// count and almost-full/almost-empty thresholds.
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH         = DEFAULT_DEPTH,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     i_wreq,
    input  logic                     i_rreq,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     o_wready,
    output logic                     o_rready,
    output logic                     fifo_isfull,
    output logic                     fifo_isempty,
    output logic                     o_almost_full,
    output logic                     o_almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    input  logic                     i_err_clr,
    output logic                     o_overflow,
    output logic                     o_underflow,
`endif
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = count_width(DEPTH);

    localparam fifo_flags_t FLAGS_RST = '{
        full:   1'b0,
        empty:  1'b1,
        afull:  (AFULL_THRESH == 0),
        aempty: 1'b1
    };

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fifo_flags_t      flags_q, flags_d;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance, pointer advance, occupancy and next-state flags.
    always_comb begin
        wr_acc   = i_wreq & ~flags_q.full;
        rd_acc   = i_rreq & ~flags_q.empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d        = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        flags_d.full   = (count_d == CNT_W'(DEPTH));
        flags_d.empty  = (count_d == CNT_W'(0));
        flags_d.afull  = (count_d >= CNT_W'(AFULL_THRESH));
        flags_d.aempty = (count_d <= CNT_W'(AEMPTY_THRESH));
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= FLAGS_RST;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
        end
    end

    fifo_ram_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (resetn),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags; a new event in the clear cycle wins over the clear.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (i_err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (i_wreq & flags_q.full) begin
            overflow_d = 1'b1;
        end
        if (i_rreq & flags_q.empty) begin
            underflow_d = 1'b1;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
`endif

    assign o_count        = count_q;
    assign fifo_isfull    = flags_q.full;
    assign fifo_isempty   = flags_q.empty;
    assign o_almost_full  = flags_q.afull;
    assign o_almost_empty = flags_q.aempty;
    assign o_wready       = ~flags_q.full;
    assign o_rready       = ~flags_q.empty;

endmodule
